// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MUL / DIVU / REMU controller.
// Borrows the Execute-stage ALU for one add or subtract per iteration.
// Only shifts and a single 33-bit compare are computed locally.
// All iteration state lives in *_q flops. The *_d next values are computed in
// one always_comb block.
module muldiv_sequencer #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] AluSrcA,
    output logic [XLEN-1:0] AluSrcB,
    output logic [2:0]      AluControl,
    input  logic [XLEN-1:0] AluResult
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

    state_t          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;         // MUL accumulator / division remainder
    logic [XLEN-1:0] mcand_q, mcand_d;     // MUL multiplicand, shifted left
    logic [XLEN-1:0] mq_q, mq_d;           // MUL multiplier / division quotient
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN:0]   rs;                   // {rem, quot msb}: partial remainder shifted in
    logic            rs_ge;
    logic            is_div;

    assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);
    assign rs     = {acc_q, mq_q[XLEN-1]};
    assign rs_ge  = rs >= {1'b0, divisor_q};

    // Next-state, datapath and ALU drive for one iteration.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mq_d       = mq_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        result_d   = result_q;
        AluSrcA    = '0;
        AluSrcB    = '0;
        AluControl = ALU_ADD;

        case (state_q)
            IDLE: begin
                // Flush wins over start: a start in the same cycle is dropped.
                if (!flush && start) begin
                    op_d      = op;
                    cnt_d     = '0;
                    acc_d     = '0;
                    mcand_d   = opA;
                    divisor_d = opB;
                    mq_d      = (op == OP_MUL) ? opB : opA;
                    if (op == OP_RSVD) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else if (op != OP_MUL && opB == '0) begin
                        // Divide by zero follows the RISC-V convention.
                        result_d = (op == OP_DIVU) ? '1 : opA;
                        state_d  = DONE;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end

            RUN: begin
                if (is_div) begin
                    // Restoring step. The subtract is only kept when rs >= divisor.
                    AluControl = ALU_SUB;
                    AluSrcA    = rs[XLEN-1:0];
                    AluSrcB    = divisor_q;
                    acc_d      = rs_ge ? AluResult : rs[XLEN-1:0];
                    mq_d       = {mq_q[XLEN-2:0], rs_ge};
                end else begin
                    // Shift-add step. Add zero when the multiplier bit is clear.
                    AluControl = ALU_ADD;
                    AluSrcA    = acc_q;
                    AluSrcB    = mq_q[0] ? mcand_q : '0;
                    acc_d      = AluResult;
                    mcand_d    = mcand_q << 1;
                    mq_d       = mq_q >> 1;
                end
                cnt_d = cnt_q + 6'd1;

                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d  = DONE;
                    result_d = (op_q == OP_DIVU) ? mq_d :
                               (op_q == OP_REMU) ? acc_d : acc_d;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset takes priority over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mq_q      <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mq_q      <= mq_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer. It models the external ALU and scores
// results against plain-arithmetic MUL/DIVU/REMU.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] alu_result;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [W-1:0] model_result = '0;

    muldiv_sequencer #(.XLEN(W), .ITER(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .opA       (op_a),
        .opB       (op_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .AluSrcA   (alu_a),
        .AluSrcB   (alu_b),
        .AluControl(alu_ctrl),
        .AluResult (alu_result)
    );

    // External Execute-stage ALU: ADD or SUB.
    assign alu_result = (alu_ctrl == 3'b001) ? alu_a - alu_b : alu_a + alu_b;

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (o)
            2'b00:   return a * b;
            2'b01:   return (b == 0) ? {W{1'b1}} : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic bit is_short(input logic [1:0] o, input logic [W-1:0] b);
        return (o == 2'b11) || (o != 2'b00 && b == 0);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation on every done and checks result stability otherwise.
    task automatic monitor();
        logic [W-1:0] e;
        int           c;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done=1 result=%h, expected no done (cycle %0d)",
                             result, cyc);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("done_result", result, e);
                    check_int("done_cycle", cyc, c);
                    model_result = e;
                end
            end else begin
                check("result_hold", result, model_result);
            end
            if (reset) model_result = '0;
        end
    endtask

    // Drive a one-cycle start; optionally push the expected result and done cycle.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit expect_it);
        op    = o;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_it) begin
            exp_q.push_back(ref_model(o, a, b));
            exp_cyc_q.push_back(cyc + (is_short(o, b) ? 0 : 32));
        end
    endtask

    // Follow an operation to completion, checking ALU drive and busy length.
    task automatic wait_done(input logic [1:0] o, input int exp_busy, input bit poke_run,
                             input bit poke_done);
        int busy_n = 0;
        bit seen   = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) begin
                seen = 1;
                check("done_alu_ctrl", {29'd0, alu_ctrl}, '0);
                check("done_alu_a", alu_a, '0);
                check("done_alu_b", alu_b, '0);
            end else begin
                if (busy) begin
                    busy_n++;
                    check("run_alu_ctrl", {29'd0, alu_ctrl}, (o == 2'b00) ? 32'd0 : 32'd1);
                end
                if (poke_run && busy_n == 5) begin
                    start = 1'b1;
                    op    = 2'b11;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done within 40 cycles, expected done (cycle %0d)", cyc);
        end
        check_int("busy_cycles", busy_n, exp_busy);
        if (poke_done) begin
            start = 1'b1;
            op    = 2'b11;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check("idle_busy", {31'd0, busy}, '0);
        check("idle_done", {31'd0, done}, '0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke_run, input bit poke_done);
        issue(o, a, b, 1'b1);
        wait_done(o, is_short(o, b) ? 0 : 32, poke_run, poke_done);
    endtask

    // Stimulus, with the monitor forked alongside.
    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        op_a  = '0;
        op_b  = '0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, '0);
        check("reset_done", {31'd0, done}, '0);
        check("reset_result", result, '0);
        check("reset_alu_ctrl", {29'd0, alu_ctrl}, '0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases.
        run_op(2'b00, 32'd7, 32'd6, 1'b0, 1'b0);
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(2'b01, 32'd100, 32'd7, 1'b1, 1'b0);
        run_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op(2'b01, 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b1);
        run_op(2'b01, 32'd55, 32'd0, 1'b0, 1'b0);
        run_op(2'b10, 32'd55, 32'd0, 1'b0, 1'b0);
        run_op(2'b11, 32'd9, 32'd4, 1'b0, 1'b0);
        run_op(2'b00, 32'd0, 32'h12345678, 1'b0, 1'b0);

        // Flush at RUN cycle 10: no done, result kept.
        issue(2'b00, 32'd3, 32'd5, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, '0);
        check("flush_done", {31'd0, done}, '0);
        repeat (40) @(posedge clk);
        #1;

        // Flush in IDLE drops a simultaneous start.
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b11;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("idle_flush_busy", {31'd0, busy}, '0);
        check("idle_flush_done", {31'd0, done}, '0);
        @(posedge clk);
        #1;

        // A completed op, then reset mid-RUN of the next.
        run_op(2'b01, 32'd1000, 32'd3, 1'b0, 1'b0);
        issue(2'b00, 32'd11, 32'd13, 1'b0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset_busy", {31'd0, busy}, '0);
        check("midrun_reset_done", {31'd0, done}, '0);
        check("midrun_reset_result", result, '0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = '0;
            else if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 20);
            run_op(ro, ra, rb, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check_int("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
